// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN inter-frame space logic.
//   - can_ifs_state_t : inter-frame space tracker states
//   - MAX_OVERLOAD, INTERMISSION_BITS, SUSPEND_BITS : default timing constants
//   - OVERLOAD_WINDOW_BITS : leading intermission bits in which a dominant
//     level is an overload condition rather than a start of frame
// Configuration macro: SUSPEND_TX_EN (adds the SUSPEND state).
// -----------------------------------------------------------------------------
package can_pkg;

    localparam int MAX_OVERLOAD         = 2;
    localparam int INTERMISSION_BITS    = 3;
    localparam int SUSPEND_BITS         = 8;
    localparam int OVERLOAD_WINDOW_BITS = 2;

    typedef enum logic [2:0] {
        IFS_BUS_IDLE     = 3'd0,
        IFS_FRAME        = 3'd1,
        IFS_INTERMISSION = 3'd2,
        IFS_OVERLOAD     = 3'd3
`ifdef SUSPEND_TX_EN
        ,
        IFS_SUSPEND      = 3'd4
`endif
    } can_ifs_state_t;

endpackage

// File: rtl/can_intermission_monitor.sv
// -----------------------------------------------------------------------------
// can_intermission_monitor
// Tracks the CAN inter-frame space after each frame (end of EOF, intermission,
// optional suspend-transmission, bus idle), raises overload conditions 1 and 2
// for the overload frame generator and reports SOF / bus-idle status.
//
// Configuration macro: SUSPEND_TX_EN
//   defined   : error-passive transmitters pass through SUSPEND after intermission
//   undefined : intermission always returns to bus idle
//
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   enable                   synchronous enable, low returns everything to reset values
//   sample_point, rx_bit     bit sample strobe and sampled bus level (0 = dominant)
//   eof_last_bit             7th EOF bit marker (only honoured in FRAME)
//   rx_not_ready             receiver asks for a delayed next frame
//   error_passive_tx         node is error-passive and transmitted the last frame
//   overload_frame_complete  overload frame block has finished its frame
//   overload_condition_1/2   one-cycle overload request pulses
//   overload_count           overload frames since last SOF (saturating)
//   sof_detected             one-cycle SOF pulse
//   bus_idle, in_intermission state levels
//   intermission_done        one-cycle pulse, intermission ended recessive
// -----------------------------------------------------------------------------
module can_intermission_monitor #(
    parameter int MAX_OVERLOAD      = can_pkg::MAX_OVERLOAD,
    parameter int INTERMISSION_BITS = can_pkg::INTERMISSION_BITS,
    parameter int SUSPEND_BITS      = can_pkg::SUSPEND_BITS
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       eof_last_bit,
    input  logic       rx_not_ready,
    input  logic       error_passive_tx,
    input  logic       overload_frame_complete,
    output logic       overload_condition_1,
    output logic       overload_condition_2,
    output logic [1:0] overload_count,
    output logic       sof_detected,
    output logic       bus_idle,
    output logic       in_intermission,
    output logic       intermission_done
);

    import can_pkg::*;

    localparam logic [1:0] MAX_CNT    = 2'(MAX_OVERLOAD);
    localparam logic [3:0] INT_LAST   = 4'(INTERMISSION_BITS - 1);
    localparam logic [3:0] SUSP_LAST  = 4'(SUSPEND_BITS - 1);
    localparam logic [3:0] OVL_WINDOW = 4'(OVERLOAD_WINDOW_BITS);

    can_ifs_state_t state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]     count_q, count_d;
    logic           cond1_q, cond1_d;
    logic           cond2_q, cond2_d;
    logic           sof_q, sof_d;
    logic           done_q, done_d;
    logic           bus_idle_q, bus_idle_d;
    logic           in_int_q, in_int_d;
    logic           room_s;

    // Further overload frames are allowed only below the saturation limit.
    assign room_s = (count_q < MAX_CNT);

`ifndef SUSPEND_TX_EN
    // Without the suspend feature these inputs have no function.
    logic unused_cfg_s;
    assign unused_cfg_s = ^{error_passive_tx, SUSP_LAST};
`endif

    // Next-state, bit counter, overload counter and pulse generation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        count_d   = count_q;
        cond1_d   = 1'b0;
        cond2_d   = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        if (!enable) begin
            state_d   = IFS_BUS_IDLE;
            bit_cnt_d = 4'd0;
            count_d   = 2'd0;
        end else begin
            // A pulse raised on the previous edge is counted now, so the count
            // presented alongside the pulse is the pre-increment value.
            if ((cond1_q || cond2_q) && room_s) begin
                count_d = count_q + 2'd1;
            end else begin
                count_d = count_q;
            end
            case (state_q)
                IFS_BUS_IDLE: begin
                    if (sample_point && !rx_bit) begin
                        sof_d   = 1'b1;
                        count_d = 2'd0;
                        state_d = IFS_FRAME;
                    end else begin
                        state_d = IFS_BUS_IDLE;
                    end
                end
                IFS_FRAME: begin
                    if (sample_point && eof_last_bit) begin
                        // Dominant last EOF bit outranks a not-ready receiver.
                        if (!rx_bit && room_s) begin
                            cond2_d = 1'b1;
                            state_d = IFS_OVERLOAD;
                        end else if (rx_not_ready && room_s) begin
                            cond1_d = 1'b1;
                            state_d = IFS_OVERLOAD;
                        end else begin
                            bit_cnt_d = 4'd0;
                            state_d   = IFS_INTERMISSION;
                        end
                    end else begin
                        state_d = IFS_FRAME;
                    end
                end
                IFS_INTERMISSION: begin
                    if (sample_point) begin
                        if (!rx_bit) begin
                            // Early dominant bit requests overload unless the
                            // limit is reached; anything else is a new frame.
                            if ((bit_cnt_q < OVL_WINDOW) && room_s) begin
                                cond2_d = 1'b1;
                                state_d = IFS_OVERLOAD;
                            end else begin
                                sof_d     = 1'b1;
                                count_d   = 2'd0;
                                bit_cnt_d = 4'd0;
                                state_d   = IFS_FRAME;
                            end
                        end else if (bit_cnt_q == INT_LAST) begin
                            done_d    = 1'b1;
                            bit_cnt_d = 4'd0;
`ifdef SUSPEND_TX_EN
                            if (error_passive_tx) begin
                                state_d = IFS_SUSPEND;
                            end else begin
                                state_d = IFS_BUS_IDLE;
                            end
`else
                            state_d = IFS_BUS_IDLE;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = IFS_INTERMISSION;
                    end
                end
                IFS_OVERLOAD: begin
                    // Bus samples belong to the overload frame and are ignored.
                    if (overload_frame_complete) begin
                        bit_cnt_d = 4'd0;
                        state_d   = IFS_INTERMISSION;
                    end else begin
                        state_d = IFS_OVERLOAD;
                    end
                end
`ifdef SUSPEND_TX_EN
                IFS_SUSPEND: begin
                    if (sample_point) begin
                        if (!rx_bit) begin
                            sof_d     = 1'b1;
                            count_d   = 2'd0;
                            bit_cnt_d = 4'd0;
                            state_d   = IFS_FRAME;
                        end else if (bit_cnt_q == SUSP_LAST) begin
                            bit_cnt_d = 4'd0;
                            state_d   = IFS_BUS_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = IFS_SUSPEND;
                    end
                end
`endif
                default: begin
                    state_d   = IFS_BUS_IDLE;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
        // Level outputs follow the state being entered so they are registered.
        bus_idle_d = (state_d == IFS_BUS_IDLE);
        in_int_d   = (state_d == IFS_INTERMISSION);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IFS_BUS_IDLE;
            bit_cnt_q  <= 4'd0;
            count_q    <= 2'd0;
            cond1_q    <= 1'b0;
            cond2_q    <= 1'b0;
            sof_q      <= 1'b0;
            done_q     <= 1'b0;
            bus_idle_q <= 1'b1;
            in_int_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            count_q    <= count_d;
            cond1_q    <= cond1_d;
            cond2_q    <= cond2_d;
            sof_q      <= sof_d;
            done_q     <= done_d;
            bus_idle_q <= bus_idle_d;
            in_int_q   <= in_int_d;
        end
    end

    assign overload_condition_1 = cond1_q;
    assign overload_condition_2 = cond2_q;
    assign overload_count       = count_q;
    assign sof_detected         = sof_q;
    assign bus_idle             = bus_idle_q;
    assign in_intermission      = in_int_q;
    assign intermission_done    = done_q;

endmodule
